pc_fetch_unit: RTL
==================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter HALT_WORD, default 32'hFFFF_FFFF: instruction encoding that stops fetch.
REQ-003 Parameter TIMEOUT, default 16: maximum cycles to wait for imem_ack, range 1..255.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 next_pc  input  32  next PC from the 3-way PC select mux (pc_plus4 / branch target / jump target).
REQ-008 instr_ready  input  1  decode stage accepts instr this cycle.
REQ-009 imem_ack  input  1  instruction memory data valid.
REQ-010 imem_rdata  input  32  instruction memory read data.
REQ-011 imem_req  output  1  fetch request to instruction memory.
REQ-012 imem_addr  output  32  fetch address, always equal to pc.
REQ-013 pc  output  32  address of the instruction currently fetched or held.
REQ-014 pc_plus4  output  32  pc + 4, modulo 2^32, combinational; drives PC mux input 0.
REQ-015 instr  output  32  captured instruction.
REQ-016 instr_valid  output  1  instr holds a valid, unconsumed instruction.
REQ-017 halted  output  1  HALT_WORD was consumed; fetch stopped.
REQ-018 fetch_err  output  1  timeout or misaligned next_pc; fetch stopped.

Function
REQ-019 FSM states SHALL be IDLE, REQ, HOLD, HALTED and ERR.
REQ-020 IDLE: all request and valid outputs 0; next state is REQ unconditionally after 1 cycle.
REQ-021 REQ: imem_req=1 and imem_addr=pc; wait counter increments each cycle without imem_ack.
REQ-022 REQ with imem_ack=1: capture imem_rdata into instr, clear the wait counter, go to HOLD; imem_req drops the following cycle.
REQ-023 REQ with the counter reaching TIMEOUT and no ack: go to ERR; fetch_err=1 from the next cycle.
REQ-024 HOLD: instr_valid=1; instr and pc stay stable while instr_ready=0.
REQ-025 HOLD with instr_ready=1 and instr!=HALT_WORD: pc <= next_pc; state becomes REQ the next cycle.
REQ-026 HOLD with instr_ready=1 and instr==HALT_WORD: pc stays unchanged; state becomes HALTED.
REQ-027 HOLD with instr_ready=1 and next_pc[1:0]!=0: pc stays unchanged; state becomes ERR (misalignment takes priority over the halt check).
REQ-028 Fetch latency: at least 1 cycle from imem_req rising to instr_valid rising (zero-wait memory: ack in the first REQ cycle gives instr_valid the next cycle).
REQ-029 imem_ack outside REQ SHALL be ignored, with no capture and no state change.
REQ-030 HALTED and ERR are absorbing states: imem_req=0, instr_valid=0, and the state is left only by rst.
REQ-031 pc_plus4 at pc=32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.

Reset
REQ-032 On rst=1 at a rising edge: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0, fetch_err=0, wait counter=0.
REQ-033 rst asserted mid-fetch SHALL abandon the outstanding request; any late imem_ack is ignored (REQ-029).
REQ-034 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-035 Reset release, zero-wait memory returning 32'h1234_5678, instr_ready=1, next_pc=pc_plus4 -> imem_addr sequence 0,4,8; instr_valid high one cycle per fetch; instr=32'h1234_5678.
REQ-036 imem_ack delayed 3 cycles, instr_ready held 0 for 5 cycles -> instr, pc stable; instr_valid stays 1 through the 5 stalled cycles; no second imem_req.
REQ-037 next_pc=32'h0000_0040 (branch) on consume -> next imem_addr=32'h40; next_pc=32'h0000_0042 -> fetch_err=1, imem_req=0 thereafter.
REQ-038 TIMEOUT=4, imem_ack never asserted -> fetch_err=1 after 4 REQ cycles; later imem_ack ignored.
REQ-039 instr=HALT_WORD consumed -> halted=1, imem_req=0 permanently; rst then -> pc=RESET_PC, halted=0, fetch resumes.
REQ-040 rst pulsed while in REQ with ack arriving the same cycle -> instr=0, instr_valid=0, state IDLE, pc=RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: single-outstanding instruction fetch with hold, halt and timeout/misalignment error
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        instr_ready,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        halted,
  output logic        fetch_err
);
  typedef enum logic [2:0] {IDLE, REQ, HOLD, HALTED, ERR} state_t;
  state_t state, state_nx;
  logic [7:0] cnt;
  logic timeout_hit;
  assign timeout_hit = cnt == 8'(TIMEOUT - 1);
  assign imem_req    = state == REQ;
  assign instr_valid = state == HOLD;
  assign halted      = state == HALTED;
  assign fetch_err   = state == ERR;
  assign imem_addr   = pc;
  assign pc_plus4    = pc + 32'd4;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // next state: misalignment is checked before the halt word
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = REQ;
      REQ:     state_nx = imem_ack ? HOLD : timeout_hit ? ERR : REQ;
      HOLD:    state_nx = !instr_ready ? HOLD : next_pc[1:0] != 2'b00 ? ERR : instr == HALT_WORD ? HALTED : REQ;
      default: state_nx = state;
    endcase
  end
  // datapath: wait counter, instruction capture, pc advance on consume
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      instr <= '0;
      cnt   <= '0;
    end else begin
      if (state == REQ) cnt <= imem_ack ? '0 : cnt + 8'd1;
      if (state == REQ && imem_ack) instr <= imem_rdata;
      if (state == HOLD && state_nx == REQ) pc <= next_pc;
    end
  end
endmodule
